// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction-fetch unit.
package ifu_pkg;

    localparam int CPU_WIDTH = 64;
    localparam int INS_WIDTH = 32;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } ifu_state_e;

    localparam logic [INS_WIDTH-1:0] NOP_INS = 32'h0000_0013;
    localparam logic [CPU_WIDTH-1:0] PC_STEP = 64'd4;

    // Redirect targets are forced onto a 4-byte instruction boundary.
    function automatic logic [CPU_WIDTH-1:0] align_pc(input logic [CPU_WIDTH-1:0] pc);
        return pc & ~(64'h3);
    endfunction

endpackage

// File: rtl/ifu_fetch.sv
// Instruction-fetch unit: owns the fetch PC, issues one imem read at a time
// and presents the returned instruction to the IF/ID register.
module ifu_fetch
    import ifu_pkg::*;
#(
    parameter logic [CPU_WIDTH-1:0] RESET_PC = 64'h8000_0000
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_redirect,
    input  logic [CPU_WIDTH-1:0] i_redirect_pc,
    output logic                 o_imem_req_valid,
    input  logic                 i_imem_req_ready,
    output logic [CPU_WIDTH-1:0] o_imem_addr,
    input  logic                 i_imem_rsp_valid,
    input  logic [INS_WIDTH-1:0] i_imem_rsp_data,
    output logic                 if_valid_o,
    input  logic                 if_ready_i,
    output logic [INS_WIDTH-1:0] o_ifu_ins,
    output logic [CPU_WIDTH-1:0] o_ifu_pc
);

    logic [CPU_WIDTH-1:0] pc;
    ifu_state_e           state;
    logic [INS_WIDTH-1:0] ins_buf;
    logic                 drop;

    logic [CPU_WIDTH-1:0] redir_pc;
    logic                 deliver;

    assign redir_pc         = align_pc(i_redirect_pc);
    assign o_imem_req_valid = (state == REQ);
    assign o_imem_addr      = pc;
    // A redirect masks delivery so the instruction is never consumed.
    assign if_valid_o       = (state == HOLD) & ~i_redirect;
    assign o_ifu_ins        = ins_buf;
    assign o_ifu_pc         = pc;
    assign deliver          = if_valid_o & if_ready_i;

    always_ff @(posedge i_clk) begin
        if (i_rst_n) begin
            pc      <= RESET_PC;
            state   <= REQ;
            ins_buf <= NOP_INS;
            drop    <= 1'b0;
        end else begin
            case (state)
                REQ: begin
                    if (i_redirect) begin
                        pc <= redir_pc;
                        // The old address was already accepted; its data must be discarded.
                        if (i_imem_req_ready) begin
                            state <= WAIT;
                            drop  <= 1'b1;
                        end
                    end else if (i_imem_req_ready) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (i_redirect) begin
                        pc   <= redir_pc;
                        drop <= 1'b1;
                    end
                    if (i_imem_rsp_valid) begin
                        if (drop | i_redirect) begin
                            drop  <= 1'b0;
                            state <= REQ;
                        end else begin
                            ins_buf <= i_imem_rsp_data;
                            state   <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (i_redirect) begin
                        pc    <= redir_pc;
                        state <= REQ;
                    end else if (deliver) begin
                        pc    <= pc + PC_STEP;
                        state <= REQ;
                    end
                end
                default: state <= REQ;
            endcase
        end
    end

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: directed scenarios plus a randomized run against a
// PC-stream reference model and a single-slot memory model.
module tb_ifu_fetch;
    import ifu_pkg::*;

    localparam logic [63:0] RPC = 64'h8000_0000;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_redirect;
    logic [63:0] i_redirect_pc;
    logic        o_imem_req_valid;
    logic        i_imem_req_ready;
    logic [63:0] o_imem_addr;
    logic        i_imem_rsp_valid;
    logic [31:0] i_imem_rsp_data;
    logic        if_valid_o;
    logic        if_ready_i;
    logic [31:0] o_ifu_ins;
    logic [63:0] o_ifu_pc;

    ifu_fetch #(.RESET_PC(RPC)) dut (
        .i_clk            (i_clk),
        .i_rst_n          (i_rst_n),
        .i_redirect       (i_redirect),
        .i_redirect_pc    (i_redirect_pc),
        .o_imem_req_valid (o_imem_req_valid),
        .i_imem_req_ready (i_imem_req_ready),
        .o_imem_addr      (o_imem_addr),
        .i_imem_rsp_valid (i_imem_rsp_valid),
        .i_imem_rsp_data  (i_imem_rsp_data),
        .if_valid_o       (if_valid_o),
        .if_ready_i       (if_ready_i),
        .o_ifu_ins        (o_ifu_ins),
        .o_ifu_pc         (o_ifu_pc)
    );

    always #5 i_clk = ~i_clk;

    int          n_chk  = 0;
    int          n_pass = 0;
    logic        pend;
    logic [63:0] pend_addr;
    int          lat;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'h1357_9BDF;
    endfunction

    task automatic tick;
        @(posedge i_clk);
        #2;
    endtask

    task automatic idle_inputs;
        i_redirect       = 1'b0;
        i_redirect_pc    = '0;
        i_imem_req_ready = 1'b0;
        i_imem_rsp_valid = 1'b0;
        i_imem_rsp_data  = '0;
        if_ready_i       = 1'b0;
    endtask

    task automatic do_reset;
        idle_inputs();
        i_rst_n = 1'b1;
        tick();
        tick();
        i_rst_n = 1'b0;
        pend    = 1'b0;
        lat     = 0;
    endtask

    task automatic mem_drive;
        i_imem_rsp_valid = pend && (lat == 0);
        i_imem_rsp_data  = (pend && lat == 0) ? mem_word(pend_addr) : 32'h0;
    endtask

    task automatic mem_update(input int new_lat);
        if (i_imem_rsp_valid && pend) pend = 1'b0;
        else if (pend && lat > 0) lat--;
        if (o_imem_req_valid && i_imem_req_ready) begin
            pend      = 1'b1;
            pend_addr = o_imem_addr;
            lat       = new_lat;
        end
    endtask

    task automatic test_reset;
        idle_inputs();
        i_rst_n = 1'b1;
        tick();
        #1;
        n_chk++; if (o_imem_req_valid !== 1'b1) $display("FAIL reset_req_valid: got %b want 1", o_imem_req_valid); else n_pass++;
        n_chk++; if (o_imem_addr !== RPC) $display("FAIL reset_addr: got %h want %h", o_imem_addr, RPC); else n_pass++;
        n_chk++; if (if_valid_o !== 1'b0) $display("FAIL reset_if_valid: got %b want 0", if_valid_o); else n_pass++;
        n_chk++; if (o_ifu_ins !== 32'h13) $display("FAIL reset_ins: got %h want 00000013", o_ifu_ins); else n_pass++;
        n_chk++; if (o_ifu_pc !== RPC) $display("FAIL reset_pc: got %h want %h", o_ifu_pc, RPC); else n_pass++;
        i_rst_n = 1'b0;
        pend    = 1'b0;
    endtask

    task automatic test_stream;
        int n_req;
        logic [63:0] epc;
        do_reset();
        n_req = 0;
        for (int k = 0; k < 9; k++) begin
            i_imem_req_ready = 1'b1;
            if_ready_i       = 1'b1;
            mem_drive();
            #1;
            n_chk++; if (if_valid_o !== ((k % 3 == 2) ? 1'b1 : 1'b0)) $display("FAIL stream_valid_c%0d: got %b want %b", k, if_valid_o, (k % 3 == 2)); else n_pass++;
            if (if_valid_o) begin
                epc = RPC + 64'(4 * (k / 3));
                n_chk++; if (o_ifu_pc !== epc) $display("FAIL stream_pc: got %h want %h", o_ifu_pc, epc); else n_pass++;
                n_chk++; if (o_ifu_ins !== mem_word(epc)) $display("FAIL stream_ins: got %h want %h", o_ifu_ins, mem_word(epc)); else n_pass++;
            end
            if (o_imem_req_valid && i_imem_req_ready) begin
                epc = RPC + 64'(4 * n_req);
                n_chk++; if (o_imem_addr !== epc) $display("FAIL stream_addr: got %h want %h", o_imem_addr, epc); else n_pass++;
                n_req++;
            end
            mem_update(0);
            tick();
        end
        n_chk++; if (n_req !== 3) $display("FAIL stream_req_count: got %0d want 3", n_req); else n_pass++;
    endtask

    task automatic test_stall;
        do_reset();
        i_imem_req_ready = 1'b1;
        if_ready_i       = 1'b0;
        for (int k = 0; k < 2; k++) begin
            mem_drive(); #1; mem_update(0); tick();
        end
        for (int k = 0; k < 5; k++) begin
            mem_drive();
            #1;
            n_chk++; if (if_valid_o !== 1'b1) $display("FAIL stall_valid_c%0d: got %b want 1", k, if_valid_o); else n_pass++;
            n_chk++; if (o_ifu_pc !== RPC) $display("FAIL stall_pc: got %h want %h", o_ifu_pc, RPC); else n_pass++;
            n_chk++; if (o_ifu_ins !== mem_word(RPC)) $display("FAIL stall_ins: got %h want %h", o_ifu_ins, mem_word(RPC)); else n_pass++;
            n_chk++; if (o_imem_req_valid !== 1'b0) $display("FAIL stall_no_req: got %b want 0", o_imem_req_valid); else n_pass++;
            mem_update(0);
            tick();
        end
        if_ready_i = 1'b1;
        i_imem_req_ready = 1'b0;
        #1;
        n_chk++; if (if_valid_o !== 1'b1) $display("FAIL stall_release_valid: got %b want 1", if_valid_o); else n_pass++;
        tick();
        #1;
        n_chk++; if (o_imem_req_valid !== 1'b1) $display("FAIL stall_next_req: got %b want 1", o_imem_req_valid); else n_pass++;
        n_chk++; if (o_imem_addr !== RPC + 64'd4) $display("FAIL stall_next_addr: got %h want %h", o_imem_addr, RPC + 64'd4); else n_pass++;
    endtask

    task automatic test_redirect_wait;
        logic [63:0] tgt;
        tgt = 64'h8000_0100;
        do_reset();
        i_imem_req_ready = 1'b1;
        if_ready_i       = 1'b1;
        mem_drive(); #1; mem_update(0); tick();
        i_imem_req_ready = 1'b0;
        i_redirect       = 1'b1;
        i_redirect_pc    = 64'h8000_0103;
        i_imem_rsp_valid = 1'b0;
        #1;
        n_chk++; if (if_valid_o !== 1'b0) $display("FAIL rw_valid_redirect: got %b want 0", if_valid_o); else n_pass++;
        tick();
        i_redirect       = 1'b0;
        i_imem_rsp_valid = 1'b1;
        i_imem_rsp_data  = 32'hDEAD_BEEF;
        #1;
        n_chk++; if (o_imem_addr !== tgt) $display("FAIL rw_addr_aligned: got %h want %h", o_imem_addr, tgt); else n_pass++;
        n_chk++; if (if_valid_o !== 1'b0) $display("FAIL rw_valid_late_rsp: got %b want 0", if_valid_o); else n_pass++;
        tick();
        pend = 1'b0;
        i_imem_rsp_valid = 1'b0;
        i_imem_req_ready = 1'b1;
        #1;
        n_chk++; if (o_imem_req_valid !== 1'b1) $display("FAIL rw_refetch_req: got %b want 1", o_imem_req_valid); else n_pass++;
        n_chk++; if (o_imem_addr !== tgt) $display("FAIL rw_refetch_addr: got %h want %h", o_imem_addr, tgt); else n_pass++;
        n_chk++; if (if_valid_o !== 1'b0) $display("FAIL rw_valid_dropped: got %b want 0", if_valid_o); else n_pass++;
        mem_update(0); tick();
        i_imem_req_ready = 1'b0;
        mem_drive(); #1; mem_update(0); tick();
        mem_drive();
        #1;
        n_chk++; if (if_valid_o !== 1'b1) $display("FAIL rw_deliver_valid: got %b want 1", if_valid_o); else n_pass++;
        n_chk++; if (o_ifu_pc !== tgt) $display("FAIL rw_deliver_pc: got %h want %h", o_ifu_pc, tgt); else n_pass++;
        n_chk++; if (o_ifu_ins !== mem_word(tgt)) $display("FAIL rw_deliver_ins: got %h want %h", o_ifu_ins, mem_word(tgt)); else n_pass++;
    endtask

    task automatic test_redirect_hold;
        logic [63:0] tgt;
        tgt = 64'h9000_0010;
        do_reset();
        i_imem_req_ready = 1'b1;
        if_ready_i       = 1'b0;
        for (int k = 0; k < 2; k++) begin
            mem_drive(); #1; mem_update(0); tick();
        end
        i_imem_req_ready = 1'b0;
        if_ready_i       = 1'b1;
        i_redirect       = 1'b1;
        i_redirect_pc    = tgt;
        #1;
        n_chk++; if (if_valid_o !== 1'b0) $display("FAIL rh_valid_masked: got %b want 0", if_valid_o); else n_pass++;
        tick();
        i_redirect = 1'b0;
        #1;
        n_chk++; if (o_imem_req_valid !== 1'b1) $display("FAIL rh_req: got %b want 1", o_imem_req_valid); else n_pass++;
        n_chk++; if (o_imem_addr !== tgt) $display("FAIL rh_addr: got %h want %h", o_imem_addr, tgt); else n_pass++;
        i_imem_req_ready = 1'b1;
        if_ready_i       = 1'b0;
        for (int k = 0; k < 2; k++) begin
            mem_drive(); #1; mem_update(0); tick();
        end
        mem_drive();
        #1;
        n_chk++; if (o_ifu_pc !== tgt) $display("FAIL rh_deliver_pc: got %h want %h", o_ifu_pc, tgt); else n_pass++;
        n_chk++; if (o_ifu_ins !== mem_word(tgt)) $display("FAIL rh_deliver_ins: got %h want %h", o_ifu_ins, mem_word(tgt)); else n_pass++;
    endtask

    task automatic test_mem_stall;
        logic [63:0] tgt;
        logic [63:0] want;
        tgt = 64'h8000_2000;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            i_redirect    = (i == 2);
            i_redirect_pc = 64'h8000_2002;
            #1;
            want = (i <= 2) ? RPC : tgt;
            n_chk++; if (o_imem_req_valid !== 1'b1) $display("FAIL ms_req_held_c%0d: got %b want 1", i, o_imem_req_valid); else n_pass++;
            n_chk++; if (o_imem_addr !== want) $display("FAIL ms_addr_c%0d: got %h want %h", i, o_imem_addr, want); else n_pass++;
            tick();
        end
        i_redirect       = 1'b0;
        i_imem_req_ready = 1'b1;
        #1;
        n_chk++; if (o_imem_addr !== tgt) $display("FAIL ms_accept_addr: got %h want %h", o_imem_addr, tgt); else n_pass++;
        mem_update(0); tick();
        mem_drive();
        #1;
        n_chk++; if (o_imem_req_valid !== 1'b0) $display("FAIL ms_single_req: got %b want 0", o_imem_req_valid); else n_pass++;
        mem_update(0); tick();
        mem_drive();
        #1;
        n_chk++; if (o_ifu_pc !== tgt) $display("FAIL ms_deliver_pc: got %h want %h", o_ifu_pc, tgt); else n_pass++;
        n_chk++; if (o_ifu_ins !== mem_word(tgt)) $display("FAIL ms_deliver_ins: got %h want %h", o_ifu_ins, mem_word(tgt)); else n_pass++;
    endtask

    task automatic test_reset_mid;
        do_reset();
        i_imem_req_ready = 1'b1;
        mem_drive(); #1; mem_update(0); tick();
        i_imem_req_ready = 1'b0;
        i_rst_n = 1'b1;
        tick();
        i_rst_n = 1'b0;
        pend    = 1'b0;
        i_imem_rsp_valid = 1'b1;
        i_imem_rsp_data  = 32'hDEAD_BEEF;
        #1;
        n_chk++; if (o_imem_req_valid !== 1'b1) $display("FAIL rm_req: got %b want 1", o_imem_req_valid); else n_pass++;
        n_chk++; if (o_imem_addr !== RPC) $display("FAIL rm_addr: got %h want %h", o_imem_addr, RPC); else n_pass++;
        n_chk++; if (if_valid_o !== 1'b0) $display("FAIL rm_valid: got %b want 0", if_valid_o); else n_pass++;
        tick();
        i_imem_rsp_valid = 1'b0;
        #1;
        n_chk++; if (o_imem_req_valid !== 1'b1) $display("FAIL rm_stale_ignored: got %b want 1", o_imem_req_valid); else n_pass++;
        n_chk++; if (if_valid_o !== 1'b0) $display("FAIL rm_valid_after: got %b want 0", if_valid_o); else n_pass++;
        n_chk++; if (o_ifu_ins !== 32'h13) $display("FAIL rm_ins_nop: got %h want 00000013", o_ifu_ins); else n_pass++;
        i_imem_req_ready = 1'b1;
        mem_drive(); #1; mem_update(0); tick();
        i_imem_req_ready = 1'b0;
        mem_drive(); #1; mem_update(0); tick();
        mem_drive();
        #1;
        n_chk++; if (o_ifu_ins !== mem_word(RPC)) $display("FAIL rm_refetch_ins: got %h want %h", o_ifu_ins, mem_word(RPC)); else n_pass++;
    endtask

    // Reference: the delivered stream is RESET_PC, +4 per consumed
    // instruction, restarted at every (aligned) redirect target.
    task automatic test_random;
        logic [63:0] exp_pc;
        int          n_del;
        do_reset();
        exp_pc = RPC;
        n_del  = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            i_imem_req_ready = ($urandom_range(3) != 0);
            if_ready_i       = ($urandom_range(2) != 0);
            i_redirect       = ($urandom_range(11) == 0);
            i_redirect_pc    = {$urandom, $urandom};
            if ($urandom_range(3) == 0) i_redirect_pc[63:4] = '1;
            if (pend && lat == 0) begin
                i_imem_rsp_valid = 1'b1;
                i_imem_rsp_data  = mem_word(pend_addr);
            end else if (!pend && $urandom_range(7) == 0) begin
                i_imem_rsp_valid = 1'b1;
                i_imem_rsp_data  = 32'hBAD0_BAD0;
            end else begin
                i_imem_rsp_valid = 1'b0;
                i_imem_rsp_data  = '0;
            end
            #1;
            if (i_redirect) begin
                n_chk++; if (if_valid_o !== 1'b0) $display("FAIL rnd_valid_on_redirect c%0d: got %b want 0", cyc, if_valid_o); else n_pass++;
                exp_pc = i_redirect_pc & ~64'h3;
            end else if (if_valid_o && if_ready_i) begin
                n_chk++; if (o_ifu_pc !== exp_pc) $display("FAIL rnd_pc c%0d: got %h want %h", cyc, o_ifu_pc, exp_pc); else n_pass++;
                n_chk++; if (o_ifu_ins !== mem_word(exp_pc)) $display("FAIL rnd_ins c%0d: got %h want %h", cyc, o_ifu_ins, mem_word(exp_pc)); else n_pass++;
                exp_pc = exp_pc + 64'd4;
                n_del++;
            end
            if (i_imem_rsp_valid && pend) pend = 1'b0;
            else if (pend && lat > 0) lat--;
            if (o_imem_req_valid && i_imem_req_ready) begin
                n_chk++; if (pend !== 1'b0) $display("FAIL rnd_outstanding c%0d: got %b want 0", cyc, pend); else n_pass++;
                pend      = 1'b1;
                pend_addr = o_imem_addr;
                lat       = $urandom_range(2);
            end
            tick();
        end
        n_chk++; if (n_del < 100) $display("FAIL rnd_progress: got %0d deliveries want >= 100", n_del); else n_pass++;
    endtask

    initial begin
        i_rst_n = 1'b1;
        idle_inputs();
        pend = 1'b0;
        pend_addr = '0;
        lat = 0;
        test_reset();
        test_stream();
        test_stall();
        test_redirect_wait();
        test_redirect_hold();
        test_mem_stall();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
- Instruction-fetch unit; sits directly upstream of the IF/ID pipeline register and drives its instruction, PC and valid inputs.
- Owns the architectural fetch PC.
- Issues one instruction-memory read at a time over a valid/ready request channel, then captures the response.
- Presents the instruction downstream under the same valid/ready handshake the IF/ID register uses. Handles redirects (branch/jump/trap) at any point in a fetch.

Parameters:
RESET_PC, 64'h8000_0000, fetch address after reset
(`CPU_WIDTH = 64 and `INS_WIDTH = 32 come from config.sv; they are not parameters)

Ports:
i_clk  in  1  clock
i_rst_n  in  1  reset, synchronous and active-high (asserted = 1 resets)
i_redirect  in  1  redirect request, one-cycle pulse
i_redirect_pc  in  CPU_WIDTH  redirect target
o_imem_req_valid  out  1  memory read request valid
i_imem_req_ready  in  1  memory accepts request
o_imem_addr  out  CPU_WIDTH  read address
i_imem_rsp_valid  in  1  read data valid
i_imem_rsp_data  in  INS_WIDTH  read data
if_valid_o  out  1  instruction valid to IF/ID
if_ready_i  in  1  IF/ID ready (its if_ready_o)
o_ifu_ins  out  INS_WIDTH  instruction to IF/ID
o_ifu_pc  out  CPU_WIDTH  PC of o_ifu_ins

Behaviour:
- Registers:
  - pc (CPU_WIDTH)
  - state (2 bits)
  - ins_buf (INS_WIDTH)
  - drop (1 bit)
- Reset (i_rst_n = 1 at a clock edge):
  - pc = RESET_PC, state = REQ, drop = 0, ins_buf = 32'h13 (nop).
  - A reset asserted mid-fetch abandons the fetch. Any later stale response is ignored because drop = 0 and state = REQ.
- Outputs during and after reset:
  - o_imem_req_valid = 1 only in REQ.
  - o_imem_addr = pc.
  - if_valid_o = (state == HOLD) & ~i_redirect.
  - o_ifu_ins = ins_buf.
  - o_ifu_pc = pc.
- Redirect target is aligned before use: pc = {i_redirect_pc[63:2], 2'b00}.
- States and transitions, in priority order:
  - REQ:
    - i_redirect: pc = target. If i_imem_req_ready was also high, go to WAIT with drop = 1; otherwise stay in REQ with the new address.
    - Else i_imem_req_ready: go to WAIT.
  - WAIT:
    - i_redirect: pc = target, drop = 1.
    - i_imem_rsp_valid with drop or i_redirect: discard the data, drop = 0, go to REQ.
    - i_imem_rsp_valid otherwise: ins_buf = i_imem_rsp_data, go to HOLD.
  - HOLD:
    - i_redirect: discard ins_buf, pc = target, go to REQ.
    - Else if_valid_o & if_ready_i: pc = pc + 4 (wraps modulo 2^64), go to REQ.
    - Else stay in HOLD; ins_buf and pc are held stable.
- Memory request channel:
  - Address changes while the request is unaccepted only on redirect.
  - At most one outstanding request.
- Memory response channel:
  - No response-side backpressure.
  - i_imem_rsp_valid outside WAIT is ignored.
- Latency and throughput: with memory ready and a 1-cycle response, an instruction is presented 2 cycles after request; best throughput is 1 instruction per 3 cycles.
- Redirect takes priority over delivery in the same cycle: if_valid_o is forced to 0, so the instruction is never consumed.
- A redirect in the same cycle as a response marks that response dropped; it is never buffered.

Decomposition:
- Package ifu_pkg:
  - state enum {REQ, WAIT, HOLD}
  - NOP_INS = 32'h13
  - PC_STEP = 4
- No sub-module is needed. PC, state and ins_buf can use the existing stl_reg (WIDTH = CPU_WIDTH; RESET_VAL = RESET_PC for pc, NOP_INS for ins_buf).

Test Plan:
- Reset release, memory always ready, 1-cycle response, if_ready_i = 1 → o_imem_addr sequence 0x8000_0000, 0x8000_0004, 0x8000_0008. Each instruction is delivered with the matching o_ifu_pc. if_valid_o pulses every 3rd cycle.
- Downstream stall: if_ready_i = 0 for 5 cycles while in HOLD → if_valid_o stays 1, ins/pc stable, no new request issued. If_ready_i = 1 → pc advances by 4.
- Redirect in WAIT to 0x8000_0103 → addr becomes 0x8000_0100. The late response (data 0xDEAD_BEEF) is dropped and never presented; the next fetch uses 0x8000_0100.
- Redirect in HOLD with if_ready_i = 1 in the same cycle → if_valid_o = 0 that cycle, no consumption, next request to the target.
- Memory not ready for 4 cycles in REQ → o_imem_req_valid held, address stable. Redirect during this window changes the address to the target without an extra request.
- Reset asserted in WAIT, then response arrives → response ignored; state REQ, addr = RESET_PC, if_valid_o = 0.
